// File: rtl/bcd_scan_ctrl.sv
// Signed result to 3-digit BCD (sequential double-dabble) plus digit-scan mux for the 7-segment decoder.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero digit slots.
module bcd_scan_ctrl #(
    parameter int WIDTH       = 10,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en_in,
    output logic             busy,
    output logic             done,
    output logic [1:0]       count,
    output logic [3:0]       num,
    output logic             sign,
    output logic             en
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t           state, state_nxt;
    logic [11:0]      bcd, bcd_adj;
    logic [WIDTH-1:0] mag;
    logic [CW-1:0]    iter;
    logic             sign_pending;
    logic [3:0]       ones, tens, hund;
    logic             loaded;
    logic [PW-1:0]    presc;

    logic signed [WIDTH:0] val_ext;
    logic [WIDTH:0]        mag_abs;
    logic                  wrap, fin, loaded_nxt, en_nxt;
    logic [1:0]            count_nxt;
    logic [3:0]            src_ones, src_tens, src_hund, num_nxt;

    always_comb begin
        val_ext = {value[WIDTH-1], value};
        mag_abs = value[WIDTH-1] ? (-val_ext) : val_ext;
        for (int i = 0; i < 3; i++) begin
            bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? (bcd[i*4 +: 4] + 4'd3) : bcd[i*4 +: 4];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (iter == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The magnitude's top bit is always 0 for legal widths; it seeds the BCD LSB so the full result enters the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd          <= '0;
            mag          <= '0;
            iter         <= '0;
            sign_pending <= 1'b0;
            ones         <= '0;
            tens         <= '0;
            hund         <= '0;
            sign         <= 1'b0;
            loaded       <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: if (load) begin
                    sign_pending <= value[WIDTH-1];
                    mag          <= mag_abs[WIDTH-1:0];
                    bcd          <= {11'd0, mag_abs[WIDTH]};
                    iter         <= CW'(WIDTH);
                end
                CONV: begin
                    {bcd, mag} <= {bcd_adj[10:0], mag, 1'b0};
                    iter       <= iter - CW'(1);
                end
                FIN: begin
                    ones   <= bcd[3:0];
                    tens   <= bcd[7:4];
                    hund   <= bcd[11:8];
                    sign   <= sign_pending;
                    loaded <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CONV);

    // Digits being committed this edge feed the mux directly so num and done appear together.
    always_comb begin
        wrap       = (presc == PW'(REFRESH_DIV - 1));
        count_nxt  = wrap ? count + 2'd1 : count;
        fin        = (state == FIN);
        src_ones   = fin ? bcd[3:0]   : ones;
        src_tens   = fin ? bcd[7:4]   : tens;
        src_hund   = fin ? bcd[11:8]  : hund;
        loaded_nxt = loaded | fin;
        case (count_nxt)
            2'd0:    num_nxt = src_ones;
            2'd1:    num_nxt = src_tens;
            2'd2:    num_nxt = src_hund;
            default: num_nxt = 4'd0;
        endcase
        en_nxt = en_in & loaded_nxt;
`ifdef LEADING_ZERO_BLANK_EN
        if ((count_nxt == 2'd2) && (src_hund == 4'd0))
            en_nxt = 1'b0;
        if ((count_nxt == 2'd1) && (src_hund == 4'd0) && (src_tens == 4'd0))
            en_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            count <= '0;
            num   <= '0;
            en    <= 1'b0;
        end else begin
            presc <= wrap ? '0 : presc + PW'(1);
            count <= count_nxt;
            num   <= num_nxt;
            en    <= en_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed, table-driven bench for bcd_scan_ctrl (WIDTH=10, REFRESH_DIV=4).
// Build with or without LEADING_ZERO_BLANK_EN; expected enables follow the macro.
module tb_bcd_scan_ctrl;

    localparam int WIDTH       = 10;
    localparam int REFRESH_DIV = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             en_in = 1'b1;
    logic             busy, done, sign, en;
    logic [1:0]       count;
    logic [3:0]       num;

    int tests = 0;
    int failures = 0;

    typedef struct {
        logic signed [WIDTH-1:0] value;
        int ones;
        int tens;
        int hund;
        int sgn;
    } vec_t;

    vec_t vecs[6];

    bcd_scan_ctrl #(.WIDTH(WIDTH), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .en_in(en_in),
        .busy(busy), .done(done), .count(count), .num(num), .sign(sign), .en(en)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int expEn(input int slot, input int tens_d, input int hund_d);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 2 && hund_d == 0) return 0;
        if (slot == 1 && hund_d == 0 && tens_d == 0) return 0;
`endif
        return 1;
    endfunction

    // Pulse load for one edge; checks busy length, single done pulse at edge+11, held sign.
    task automatic applyStimulus(input logic signed [WIDTH-1:0] v, input int prev_sign);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        load  = 1'b1;
        value = v;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 0) load = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == 5) checkOutput("sign_held_during_conv", int'(sign), prev_sign);
        end
        checkOutput("busy_cycles", busy_cnt, WIDTH);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("done_latency", done_at, WIDTH + 1);
    endtask

    task automatic scanCheck(input string name, input int o, input int t, input int h, input int s);
        int exp_num[4];
        exp_num[0] = o;
        exp_num[1] = t;
        exp_num[2] = h;
        exp_num[3] = 0;
        for (int slot = 0; slot < 4; slot++) begin
            int waited = 0;
            while (int'(count) != slot && waited < 40) begin
                tick();
                waited++;
            end
            if (int'(count) != slot) begin
                tests++;
                failures++;
                $display("[TB] FAIL %s slot_wait: count %0d never reached %0d", name, count, slot);
            end else begin
                checkOutput({name, "_num"}, int'(num), exp_num[slot]);
                checkOutput({name, "_en"}, int'(en), expEn(slot, t, h));
                checkOutput({name, "_sign"}, int'(sign), s);
            end
        end
    endtask

    initial begin
        int prev_sign;
        int done_cnt;
        int done_at;

        vecs[0] = '{10'sd237,  7, 3, 2, 0};
        vecs[1] = '{-10'sd512, 2, 1, 5, 1};
        vecs[2] = '{-10'sd1,   1, 0, 0, 1};
        vecs[3] = '{10'sd7,    7, 0, 0, 0};
        vecs[4] = '{10'sd0,    0, 0, 0, 0};
        vecs[5] = '{10'sd511,  1, 1, 5, 0};

        #12 rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checkOutput("idle_count", int'(count), (k / 4) % 4);
            checkOutput("idle_en", int'(en), 0);
            checkOutput("idle_busy", int'(busy), 0);
            checkOutput("idle_num", int'(num), 0);
        end

        prev_sign = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].value, prev_sign);
            scanCheck($sformatf("vec%0d", i), vecs[i].ones, vecs[i].tens, vecs[i].hund, vecs[i].sgn);
            prev_sign = vecs[i].sgn;
        end

        // Second load three cycles into a conversion must be dropped.
        load = 1'b1;
        value = 10'sd100;
        done_cnt = 0;
        done_at = -1;
        for (int k = 0; k < 16; k++) begin
            tick();
            load = 1'b0;
            if (k == 2) begin
                load = 1'b1;
                value = 10'sd55;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        checkOutput("ignored_load_done_pulses", done_cnt, 1);
        checkOutput("ignored_load_done_latency", done_at, WIDTH + 1);
        scanCheck("ignored_load", 0, 0, 1, 0);

        // Asynchronous reset mid-conversion.
        load = 1'b1;
        value = -10'sd300;
        for (int k = 0; k < 4; k++) begin
            tick();
            load = 1'b0;
        end
        checkOutput("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_num", int'(num), 0);
        checkOutput("rst_sign", int'(sign), 0);
        checkOutput("rst_en", int'(en), 0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(10'sd42, 0);
        scanCheck("after_reset", 2, 4, 0, 0);

        en_in = 1'b0;
        tick();
        tick();
        checkOutput("en_in_low", int'(en), 0);
        en_in = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
